// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment BCD conversion path.
// Holds the controller state encoding, the dark-digit code and a digit-count helper.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Number of decimal digits needed to show the largest unsigned value of a given bit width.
  function automatic int unsigned min_digits(input int unsigned width);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << width) - 64'd1;
    n = 32'd1;
    for (int i = 0; i < 20; i++) begin
      if (v > 64'd9) begin
        v = v / 64'd10;
        n = n + 32'd1;
      end else begin
        v = v;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sevenseg_bcd_ctrl_chk.sv
// Assertion checker for the seven-segment BCD controller: parameter legality
// and basic output-protocol properties.
module sevenseg_bcd_ctrl_chk
  import sevenseg_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 6,
  parameter logic [3:0]  BLANK  = BLANK_CODE
) (
  input logic                clock,
  input logic                resetn,
  input logic                busy,
  input logic                done,
  input logic [4*DIGITS-1:0] digits
);

  function automatic logic nibbles_ok(input logic [4*DIGITS-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((d[4*i +: 4] > 4'd9) && (d[4*i +: 4] != BLANK)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  a_params_legal: assert property (@(posedge clock)
    (WIDTH >= 32'd1) && (WIDTH <= 32'd20) && (DIGITS >= min_digits(WIDTH)))
    else $error("sevenseg_bcd_ctrl: DIGITS too small for WIDTH or WIDTH out of range");

  a_done_while_busy: assert property (@(posedge clock) disable iff (!resetn)
    done |-> busy)
    else $error("sevenseg_bcd_ctrl: done raised while not busy");

  a_done_single: assert property (@(posedge clock) disable iff (!resetn)
    done |=> !done)
    else $error("sevenseg_bcd_ctrl: done held longer than one cycle");

  a_digits_legal: assert property (@(posedge clock) disable iff (!resetn)
    nibbles_ok(digits))
    else $error("sevenseg_bcd_ctrl: illegal nibble on digits");

endmodule

// File: rtl/sevenseg_dd_step.sv
// Double-dabble correction step: every BCD nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next decade.
module sevenseg_dd_step
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [4*DIGITS-1:0] adj
);

  // Per-nibble add-3 correction.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
  end

endmodule

// File: rtl/sevenseg_bcd_ctrl.sv
// Sequencing controller for the seven-segment output path: binary-to-BCD by
// iterative double-dabble with optional leading-zero blanking and a one-deep write buffer.
module sevenseg_bcd_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 6,
  parameter logic [3:0]  BLANK  = BLANK_CODE
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] digits
);

  localparam int unsigned   BW       = 4 * DIGITS;
  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  state_t            state_r;
  state_t            state_s;
  logic [WIDTH-1:0]  bin_r;
  logic [BW-1:0]     bcd_r;
  logic [BW-1:0]     bcd_adj_s;
  logic [BW-1:0]     blanked_s;
  logic [CW-1:0]     cnt_r;
  logic              lz_r;
  logic              lead_s;
  logic              pend_valid_r;
  logic [WIDTH-1:0]  pend_data_r;
  logic              pend_lz_r;
  logic              start_s;
  logic [WIDTH-1:0]  start_data_s;
  logic              start_lz_s;
  logic [BW-1:0]     digits_r;
  logic              busy_r;
  logic              done_r;

  sevenseg_dd_step #(
    .DIGITS (DIGITS)
  ) u_dd_step (
    .bcd (bcd_r),
    .adj (bcd_adj_s)
  );

  // Next-state and start-source selection; a direct write beats the pending entry.
  always_comb begin
    state_s      = state_r;
    start_s      = 1'b0;
    start_data_s = wr_data;
    start_lz_s   = blank_lz;
    case (state_r)
      IDLE: begin
        if (wr_en || pend_valid_r) begin
          start_s = 1'b1;
          state_s = CONV;
        end else begin
          state_s = IDLE;
        end
        if (wr_en) begin
          start_data_s = wr_data;
          start_lz_s   = blank_lz;
        end else begin
          start_data_s = pend_data_r;
          start_lz_s   = pend_lz_r;
        end
      end
      CONV: begin
        if (cnt_r == LAST_CNT) begin
          state_s = UPDATE;
        end else begin
          state_s = CONV;
        end
      end
      UPDATE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Leading-zero blanking from the most significant digit down; digit 0 always shows.
  always_comb begin
    blanked_s = bcd_r;
    lead_s    = lz_r;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead_s && (bcd_r[4*i +: 4] == 4'd0)) begin
        blanked_s[4*i +: 4] = BLANK;
      end else begin
        lead_s = 1'b0;
      end
    end
  end

  // State, conversion datapath and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      bin_r    <= '0;
      bcd_r    <= '0;
      cnt_r    <= '0;
      lz_r     <= 1'b0;
      digits_r <= {DIGITS{BLANK}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == UPDATE);
      case (state_r)
        IDLE: begin
          if (start_s) begin
            bin_r <= start_data_s;
            bcd_r <= '0;
            cnt_r <= '0;
            lz_r  <= start_lz_s;
          end
        end
        CONV: begin
          // WIDTH shift iterations, then one commit edge that raises done.
          if (cnt_r != LAST_CNT) begin
            {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1;
            cnt_r          <= cnt_r + CW'(1);
          end else begin
            digits_r <= blanked_s;
          end
        end
        UPDATE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // One-deep pending buffer: the last write seen while busy is kept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_valid_r <= 1'b0;
      pend_data_r  <= '0;
      pend_lz_r    <= 1'b0;
    end else if ((state_r != IDLE) && wr_en) begin
      pend_valid_r <= 1'b1;
      pend_data_r  <= wr_data;
      pend_lz_r    <= blank_lz;
    end else if (start_s) begin
      pend_valid_r <= 1'b0;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign digits = digits_r;

  sevenseg_bcd_ctrl_chk #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS),
    .BLANK  (BLANK)
  ) u_chk (
    .clock  (clock),
    .resetn (resetn),
    .busy   (busy_r),
    .done   (done_r),
    .digits (digits_r)
  );

endmodule

// File: tb/tb_sevenseg_bcd_ctrl.sv
// Scoreboard bench for sevenseg_bcd_ctrl: a cycle-level reference model pushes the
// expected display for each conversion start; a monitor pops on every done pulse.
module tb_sevenseg_bcd_ctrl;

  localparam int          WIDTH     = 16;
  localparam int          DIGITS    = 6;
  localparam logic [23:0] ALL_BLANK = 24'hFFFFFF;

  logic        clock    = 1'b0;
  logic        resetn   = 1'b1;
  logic        wr_en    = 1'b0;
  logic [15:0] wr_data  = 16'd0;
  logic        blank_lz = 1'b0;
  logic        busy;
  logic        done;
  logic [23:0] digits;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_left    = 0;
  bit          m_pv      = 1'b0;
  logic [15:0] m_pd      = 16'd0;
  bit          m_pl      = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] last_disp = ALL_BLANK;
  bit          seen_200  = 1'b0;
  int          done_count = 0;

  always #5 clock = ~clock;

  sevenseg_bcd_ctrl #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS),
    .BLANK  (4'hF)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .digits   (digits)
  );

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by division, blanking leading zeros above digit 0 when requested.
  function automatic logic [23:0] ref_digits(input int unsigned v, input bit lz);
    logic [23:0] r;
    int unsigned p;
    int unsigned d;
    bit lead;
    r = 24'd0;
    lead = lz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      d = (v / p) % 10;
      if (lead && d == 0 && i > 0) r[4*i +: 4] = 4'hF;
      else begin
        lead = 1'b0;
        r[4*i +: 4] = d[3:0];
      end
    end
    return r;
  endfunction

  // Reference model: a conversion keeps the block busy WIDTH+2 cycles, done in the last one.
  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_left = 0;
        m_pv   = 1'b0;
        exp_q.delete();
      end else if (m_left == 0) begin
        if (wr_en) begin
          exp_q.push_back(ref_digits(int'(wr_data), blank_lz));
          m_left = WIDTH + 2;
          m_pv   = 1'b0;
        end else if (m_pv) begin
          exp_q.push_back(ref_digits(int'(m_pd), m_pl));
          m_left = WIDTH + 2;
          m_pv   = 1'b0;
        end
      end else begin
        if (wr_en) begin
          m_pv = 1'b1;
          m_pd = wr_data;
          m_pl = blank_lz;
        end
        m_left = m_left - 1;
      end
    end
  end

  // Monitor: compares busy/done every cycle and pops the scoreboard on done.
  initial begin
    forever begin
      @(negedge clock);
      if (!resetn) begin
        last_disp = ALL_BLANK;
        check("digits_in_reset", digits, ALL_BLANK);
      end else begin
        check("busy", {23'd0, busy}, {23'd0, (m_left > 0)});
        check("done", {23'd0, done}, {23'd0, (m_left == 1)});
        if (digits == 24'h000200) seen_200 = 1'b1;
        if (done) begin
          done_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_unexpected: got done=1 expected no pending result at %0t", $time);
          end else begin
            last_disp = exp_q.pop_front();
            check("digits_on_done", digits, last_disp);
          end
        end else begin
          check("digits_hold", digits, last_disp);
        end
      end
    end
  end

  task automatic do_write(input int unsigned v, input bit lz);
    wr_data  = v[15:0];
    blank_lz = lz;
    wr_en    = 1'b1;
    @(negedge clock);
    wr_en    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && m_left == 0 && !m_pv && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got still busy after 200 cycles expected idle", name);
    end
  endtask

  initial begin
    int bc;
    int done_at;
    int dc0;
    bit found;
    int unsigned v;
    bit lz;

    #1 resetn = 1'b0;
    #1;
    check("reset_digits", digits, ALL_BLANK);
    check("reset_busy", {23'd0, busy}, 24'd0);
    check("reset_done", {23'd0, done}, 24'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    idle(10);
    check("idle_hold", digits, ALL_BLANK);

    do_write(1234, 1'b1);
    bc = 0;
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done && done_at < 0) done_at = i;
      @(negedge clock);
    end
    check("busy_cycles_1234", bc[23:0], 24'd18);
    check("done_edge_1234", done_at[23:0], 24'd17);
    check("digits_1234", digits, 24'hFF1234);

    do_write(0, 1'b1);
    wait_idle("idle_zero");
    check("digits_zero", digits, 24'hFFFFF0);

    do_write(65535, 1'b0);
    wait_idle("idle_max");
    check("digits_65535", digits, 24'h065535);

    seen_200 = 1'b0;
    dc0 = done_count;
    do_write(100, 1'b0);
    idle(2);
    do_write(200, 1'b0);
    idle(3);
    do_write(300, 1'b0);
    wait_idle("idle_pending");
    check("digits_300", digits, 24'h000300);
    check("pending_dones", (done_count - dc0), 24'd2);
    check("seen_200", {23'd0, seen_200}, 24'd0);

    dc0 = done_count;
    do_write(40, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("found_update_cycle", {23'd0, found}, 24'd1);
    do_write(42, 1'b0);
    wait_idle("idle_update_write");
    check("digits_42", digits, 24'h000042);
    check("update_dones", (done_count - dc0), 24'd2);

    dc0 = done_count;
    do_write(999, 1'b0);
    repeat (8) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("abort_digits", digits, ALL_BLANK);
    check("abort_busy", {23'd0, busy}, 24'd0);
    check("abort_done", {23'd0, done}, 24'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    idle(20);
    check("abort_no_done", (done_count - dc0), 24'd0);
    do_write(7, 1'b0);
    wait_idle("idle_after_abort");
    check("digits_7", digits, 24'h000007);

    for (int t = 0; t < 250; t++) begin
      v  = $urandom_range(0, 65535);
      if (t % 17 == 0) v = 65535;
      if (t % 19 == 0) v = 0;
      lz = 1'($urandom_range(0, 1));
      do_write(v, lz);
      idle($urandom_range(0, 24));
    end
    wait_idle("idle_random");
    check("scoreboard_empty", exp_q.size(), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
